// File: rtl/hammerblade_sim_controller.sv
// Simulation-run controller: delayed reset, saturating run-cycle counter and
// run termination on all-channels-done, cycle timeout or network idle.
module hammerblade_sim_controller #(
    parameter int num_channels_p   = 4,
    parameter int reset_delay_p    = 3,
    parameter int ctr_width_p      = 32,
    parameter int timeout_cycles_p = 100000,
    parameter int idle_limit_p     = 1000
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [num_channels_p-1:0] activity_i,
    input  logic [num_channels_p-1:0] done_i,
    output logic                      reset_o,
    output logic [ctr_width_p-1:0]    ctr_o,
    output logic [num_channels_p-1:0] done_r_o,
    output logic [1:0]                state_o,
    output logic                      finish_o,
    output logic                      timeout_o,
    output logic                      idle_o
);
    // Extra headroom keeps the width non-zero when idle detection is disabled.
    localparam int idle_w_lp = $clog2(idle_limit_p + 2);
    localparam logic [ctr_width_p-1:0] timeout_last_lp = ctr_width_p'(timeout_cycles_p - 1);
    localparam logic [idle_w_lp-1:0]   idle_limit_lp   = idle_w_lp'(idle_limit_p);
    localparam logic [idle_w_lp-1:0]   idle_last_lp    = idle_w_lp'(idle_limit_p - 1);

    typedef enum logic [1:0] {
        st_reset = 2'd0,
        st_run   = 2'd1,
        st_done  = 2'd2
    } state_e;

    state_e                    state;
    logic [reset_delay_p-1:0]  rst_pipe;
    logic [idle_w_lp-1:0]      idle_cnt;
    logic [num_channels_p-1:0] done_all;
    logic                      quiet;
    logic                      hit_timeout;
    logic                      hit_idle;

    // Deliberately unreset so that a reset_i pulse always propagates.
    always_ff @(posedge clk_i) begin
        rst_pipe[0] <= reset_i;
        for (int i = 1; i < reset_delay_p; i++) begin
            rst_pipe[i] <= rst_pipe[i-1];
        end
    end

    assign reset_o     = rst_pipe[reset_delay_p-1];
    assign state_o     = state;
    assign done_all    = done_r_o | done_i;
    assign quiet       = ~|activity_i;
    assign hit_timeout = (timeout_cycles_p != 0) && (ctr_o == timeout_last_lp);
    assign hit_idle    = (idle_limit_p != 0) && quiet && (idle_cnt == idle_last_lp);

    always_ff @(posedge clk_i) begin
        if (reset_o) begin
            state     <= st_reset;
            ctr_o     <= '0;
            done_r_o  <= '0;
            finish_o  <= 1'b0;
            timeout_o <= 1'b0;
            idle_o    <= 1'b0;
            idle_cnt  <= '0;
        end else begin
            case (state)
                st_reset: begin
                    state    <= st_run;
                    finish_o <= 1'b0;
                end
                st_run: begin
                    done_r_o <= done_all;
                    finish_o <= 1'b0;
                    if (ctr_o != '1) begin
                        ctr_o <= ctr_o + 1'b1;
                    end
                    if (!quiet) begin
                        idle_cnt <= '0;
                    end else if (idle_cnt != idle_limit_lp) begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                    // Completion outranks timeout, which outranks idle.
                    if (&done_all) begin
                        state    <= st_done;
                        finish_o <= 1'b1;
                    end else if (hit_timeout) begin
                        state     <= st_done;
                        finish_o  <= 1'b1;
                        timeout_o <= 1'b1;
                    end else if (hit_idle) begin
                        state    <= st_done;
                        finish_o <= 1'b1;
                        idle_o   <= 1'b1;
                    end
                end
                default: begin
                    finish_o <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_hammerblade_sim_controller.sv
// Bench for hammerblade_sim_controller: directed scenarios plus random traffic,
// all checked cycle by cycle against a behavioural run model.
module tb_hammerblade_sim_controller;
    localparam int NCH = 2;
    localparam int RD  = 3;
    localparam int TO  = 20;
    localparam int IL  = 5;

    logic        clk = 1'b0;
    logic        reset_i;
    logic [1:0]  activity_i;
    logic [1:0]  done_i;
    logic        reset_o;
    logic [31:0] ctr_o;
    logic [1:0]  done_r_o;
    logic [1:0]  state_o;
    logic        finish_o;
    logic        timeout_o;
    logic        idle_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: reset_i history, run phase (0 reset, 1 run, 2 done), counters, flags.
    logic        m_rq[$];
    int          m_phase;
    logic [31:0] m_ctr;
    logic [1:0]  m_done;
    logic        m_fin;
    logic        m_to;
    logic        m_idle;
    int          m_streak;

    hammerblade_sim_controller #(
        .num_channels_p  (NCH),
        .reset_delay_p   (RD),
        .ctr_width_p     (32),
        .timeout_cycles_p(TO),
        .idle_limit_p    (IL)
    ) dut (
        .clk_i     (clk),
        .reset_i   (reset_i),
        .activity_i(activity_i),
        .done_i    (done_i),
        .reset_o   (reset_o),
        .ctr_o     (ctr_o),
        .done_r_o  (done_r_o),
        .state_o   (state_o),
        .finish_o  (finish_o),
        .timeout_o (timeout_o),
        .idle_o    (idle_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("reset_o",   {31'd0, reset_o},   {31'd0, m_rq[0]});
        chk("ctr_o",     ctr_o,              m_ctr);
        chk("done_r_o",  {30'd0, done_r_o},  {30'd0, m_done});
        chk("state_o",   {30'd0, state_o},   32'(m_phase));
        chk("finish_o",  {31'd0, finish_o},  {31'd0, m_fin});
        chk("timeout_o", {31'd0, timeout_o}, {31'd0, m_to});
        chk("idle_o",    {31'd0, idle_o},    {31'd0, m_idle});
    endtask

    // One clock: drive inputs, advance the model, then compare after the edge.
    task automatic tick(input logic [1:0] act, input logic [1:0] dn, input logic rst);
        logic       ro;
        logic [1:0] seen;
        activity_i = act;
        done_i     = dn;
        reset_i    = rst;
        ro = m_rq[0];
        m_rq.push_back(rst);
        m_rq.delete(0);
        if (ro) begin
            m_phase = 0; m_ctr = 0; m_done = 0; m_fin = 0;
            m_to = 0; m_idle = 0; m_streak = 0;
        end else if (m_phase == 0) begin
            m_phase = 1;
            m_fin = 0;
        end else if (m_phase == 1) begin
            seen     = m_done | dn;
            m_done   = seen;
            m_streak = (act != 0) ? 0 : m_streak + 1;
            if (m_ctr != 32'hFFFF_FFFF) m_ctr = m_ctr + 1;
            m_fin = 0;
            if (seen == 2'b11) begin
                m_phase = 2; m_fin = 1;
            end else if (m_ctr == TO) begin
                m_phase = 2; m_fin = 1; m_to = 1;
            end else if (m_streak == IL) begin
                m_phase = 2; m_fin = 1; m_idle = 1;
            end
        end else begin
            m_fin = 0;
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    // Single-cycle reset_i pulse, then wait until the run restarts.
    task automatic pulse_reset();
        tick(2'b00, 2'b00, 1'b1);
        repeat (RD + 1) tick(2'b00, 2'b00, 1'b0);
        chk("restart_state", {30'd0, state_o}, 32'd1);
        chk("restart_ctr", ctr_o, 32'd0);
    endtask

    initial begin
        logic [1:0] act;
        logic [1:0] dn;
        logic       rst;
        int         rate;
        reset_i = 1'b1;
        activity_i = '0;
        done_i = '0;
        repeat (RD + 3) @(posedge clk);
        #1;
        for (int i = 0; i < RD; i++) m_rq.push_back(1'b1);
        m_phase = 0; m_ctr = 0; m_done = 0; m_fin = 0;
        m_to = 0; m_idle = 0; m_streak = 0;
        check_all();

        // Reset delay: reset_o falls RD cycles after reset_i, RUN one cycle later.
        repeat (4) tick(2'b00, 2'b00, 1'b1);
        for (int i = 0; i < RD; i++) begin
            chk("rst_delay_hold", {31'd0, reset_o}, 32'd1);
            tick(2'b00, 2'b00, 1'b0);
        end
        chk("rst_delay_low", {31'd0, reset_o}, 32'd0);
        tick(2'b00, 2'b00, 1'b0);
        chk("run_entry_state", {30'd0, state_o}, 32'd1);
        chk("run_entry_ctr", ctr_o, 32'd0);

        // All-done: channel 0 at RUN cycle 3, channel 1 at RUN cycle 6.
        for (int k = 0; k < 7; k++) begin
            tick(2'b01, (k == 3) ? 2'b01 : (k == 6) ? 2'b10 : 2'b00, 1'b0);
            if (k == 3) chk("alldone_partial", {30'd0, done_r_o}, 32'd1);
        end
        chk("alldone_finish", {31'd0, finish_o}, 32'd1);
        chk("alldone_ctr", ctr_o, 32'd7);
        repeat (3) tick(2'b01, 2'b11, 1'b0);
        chk("alldone_frozen", ctr_o, 32'd7);
        chk("alldone_nocause", {30'd0, timeout_o, idle_o}, 32'd0);
        pulse_reset();

        // Timeout with constant activity and no completion.
        for (int k = 0; k < TO; k++) tick(2'b01, 2'b00, 1'b0);
        chk("timeout_ctr", ctr_o, 32'd20);
        chk("timeout_flag", {31'd0, timeout_o}, 32'd1);
        chk("timeout_finish", {31'd0, finish_o}, 32'd1);
        repeat (3) tick(2'b11, 2'b11, 1'b0);
        chk("timeout_done_ignored", {30'd0, done_r_o}, 32'd0);
        pulse_reset();

        // Idle: activity for three cycles, then silence.
        for (int k = 0; k < 8; k++) tick((k < 3) ? 2'b10 : 2'b00, 2'b00, 1'b0);
        chk("idle_flag", {31'd0, idle_o}, 32'd1);
        chk("idle_ctr", ctr_o, 32'd8);
        repeat (2) tick(2'b00, 2'b00, 1'b0);
        pulse_reset();

        // Completion on the timeout cycle wins.
        for (int k = 0; k < TO; k++)
            tick(2'b01, (k == 5) ? 2'b01 : (k == TO - 1) ? 2'b10 : 2'b00, 1'b0);
        chk("prio_state", {30'd0, state_o}, 32'd2);
        chk("prio_cause", {30'd0, timeout_o, idle_o}, 32'd0);
        pulse_reset();

        // Mid-run reset pulse at RUN cycle 10.
        for (int k = 0; k < 10; k++) tick(2'b01, 2'b00, 1'b0);
        tick(2'b01, 2'b00, 1'b1);
        for (int k = 0; k < RD + 4; k++) tick(2'b01, 2'b00, 1'b0);

        // Random traffic with varying activity density and occasional resets.
        rate = 5;
        for (int n = 0; n < 1500; n++) begin
            if (n % 60 == 0) rate = $urandom_range(0, 10);
            act = ($urandom_range(0, 9) < rate) ? 2'($urandom_range(1, 3)) : 2'b00;
            dn  = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            rst = ($urandom_range(0, 39) == 0);
            tick(act, dn, rst);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
